// File: rtl/usb_ep_in_arbiter.sv
// rtl/usb_ep_in_arbiter.sv - packet-granular round-robin arbiter feeding one USB IN endpoint FIFO
// Grants A or B per packet, prepends a source-tag header, caps packets at MAX_PKT bytes.
module usb_ep_in_arbiter #(
  parameter int unsigned MAX_PKT = 64,
  parameter bit          HDR_EN  = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] a_data,
  input  logic       a_valid,
  input  logic       a_last,
  output logic       a_ready,
  input  logic [7:0] b_data,
  input  logic       b_valid,
  input  logic       b_last,
  output logic       b_ready,
  input  logic       ep_full,
  output logic [7:0] ep_din,
  output logic       ep_we,
  output logic [1:0] grant,
  output logic       pkt_done,
  output logic       trunc
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    DATA = 2'd2
  } state_t;

  localparam logic [7:0] CNT_LAST = 8'(MAX_PKT - 1);

  state_t     state_q, state_d;
  logic       ep_we_q, ep_we_d;
  logic [7:0] ep_din_q, ep_din_d;
  logic [1:0] grant_q, grant_d;
  logic       pkt_done_q, pkt_done_d;
  logic       trunc_q, trunc_d;
  logic [7:0] cnt_q, cnt_d;
  logic       last_b_q, last_b_d;

  logic       launch;
  logic       owner_b;
  logic       own_valid;
  logic       own_last;
  logic [7:0] own_data;

  // A write register that is still busy blocks the next launch, giving one write per two clocks.
  assign launch    = ~ep_full & ~ep_we_q;
  assign owner_b   = grant_q[1];
  assign own_valid = owner_b ? b_valid : a_valid;
  assign own_last  = owner_b ? b_last  : a_last;
  assign own_data  = owner_b ? b_data  : a_data;

  assign a_ready = (state_q == DATA) & grant_q[0] & launch;
  assign b_ready = (state_q == DATA) & grant_q[1] & launch;

  always_comb begin
    state_d    = state_q;
    ep_we_d    = 1'b0;
    ep_din_d   = ep_din_q;
    grant_d    = grant_q;
    pkt_done_d = 1'b0;
    trunc_d    = 1'b0;
    cnt_d      = cnt_q;
    last_b_d   = last_b_q;
    case (state_q)
      IDLE: begin
        if (a_valid | b_valid) begin
          // A wins when alone, or on a tie when B was served last.
          grant_d = (a_valid & (~b_valid | last_b_q)) ? 2'b01 : 2'b10;
          state_d = HDR_EN ? HDR : DATA;
          cnt_d   = '0;
        end
      end
      HDR: begin
        if (launch) begin
          ep_we_d  = 1'b1;
          ep_din_d = owner_b ? 8'hA1 : 8'hA0;
          state_d  = DATA;
        end
      end
      DATA: begin
        if (own_valid & launch) begin
          ep_we_d  = 1'b1;
          ep_din_d = own_data;
          cnt_d    = cnt_q + 8'd1;
          if (own_last | (cnt_q == CNT_LAST)) begin
            state_d    = IDLE;
            grant_d    = 2'b00;
            pkt_done_d = 1'b1;
            trunc_d    = ~own_last;
            last_b_d   = owner_b;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      ep_we_q    <= 1'b0;
      ep_din_q   <= 8'h00;
      grant_q    <= 2'b00;
      pkt_done_q <= 1'b0;
      trunc_q    <= 1'b0;
      cnt_q      <= 8'h00;
      last_b_q   <= 1'b1;
    end else begin
      state_q    <= state_d;
      ep_we_q    <= ep_we_d;
      ep_din_q   <= ep_din_d;
      grant_q    <= grant_d;
      pkt_done_q <= pkt_done_d;
      trunc_q    <= trunc_d;
      cnt_q      <= cnt_d;
      last_b_q   <= last_b_d;
    end
  end

  assign ep_we    = ep_we_q;
  assign ep_din   = ep_din_q;
  assign grant    = grant_q;
  assign pkt_done = pkt_done_q;
  assign trunc    = trunc_q;

endmodule
